// File: rtl/load_store_unit_if.sv
// Core-side request/response and word-memory signals of the load/store unit.
// slave = the LSU view, master = core plus data memory view.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall;
  logic [DATA_W-1:0] load_data;
  logic              access_fault;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output stall, load_data, access_fault, mem_address, mem_write_data, mem_write_enable
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  stall, load_data, access_fault, mem_address, mem_write_data, mem_write_enable
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store to word memory: lane steering, load extension, read-modify-write stores.
// Latency: aligned accesses complete in the request cycle; boundary-crossing ones take two (stall=1 in the first).
// LSU_MISALIGNED_EN builds the two-cycle split path; without it crossing accesses fault.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  load_store_unit_if.slave    bus
);

  logic [2:0]        f3;
  logic [1:0]        off;
  logic [2:0]        size;
  logic [2:0]        span;
  logic              legal;
  logic              split;
  logic              split_fault;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] mask_lo;
  logic [DATA_W-1:0] merge_lo;
  logic [4:0]        sh_lo;
  logic [ADDR_W-1:0] addr_lo;

  assign f3      = bus.req_funct3;
  assign off     = bus.req_addr[1:0];
  assign span    = {1'b0, off} + size;
  assign split   = span > 3'd4;
  assign sh_lo   = {off, 3'b000};
  assign addr_lo = {bus.req_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    size      = 3'd4;
    lane_mask = 32'hFFFF_FFFF;
    case (f3[1:0])
      2'b00: begin size = 3'd1; lane_mask = 32'h0000_00FF; end
      2'b01: begin size = 3'd2; lane_mask = 32'h0000_FFFF; end
      default: ;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (f3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !bus.req_write;
      default:                legal = 1'b0;
    endcase
  end

  // Lanes that fall past byte 3 are shifted out, so this also forms the first half of a split store.
  assign mask_lo  = lane_mask << sh_lo;
  assign merge_lo = (bus.mem_read_data & ~mask_lo) | ((bus.req_wdata << sh_lo) & mask_lo);

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] fn);
    case (fn)
      3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
      3'b100:  extend = {24'h0, raw[7:0]};
      3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
      3'b101:  extend = {16'h0, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

`ifdef LSU_MISALIGNED_EN
  typedef enum logic {IDLE, SECOND} state_t;

  state_t            state;
  logic [DATA_W-1:0] capture;
  logic [2:0]        rem;
  logic [5:0]        sh_hi;
  logic [DATA_W-1:0] mask_hi;
  logic [DATA_W-1:0] merge_hi;
  logic [ADDR_W-1:0] addr_hi;

  assign split_fault = 1'b0;
  assign rem         = 3'd4 - {1'b0, off};
  assign sh_hi       = {rem, 3'b000};
  assign addr_hi     = addr_lo + ADDR_W'(4);
  assign mask_hi     = lane_mask >> sh_hi;
  assign merge_hi    = (bus.mem_read_data & ~mask_hi) | ((bus.req_wdata >> sh_hi) & mask_hi);

  // Capture holds lanes off..3 of the first word right-aligned, ready to OR with the second word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      capture <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && legal && split) begin
            state <= SECOND;
            if (!bus.req_write)
              capture <= bus.mem_read_data >> sh_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign split_fault = split;
`endif

  always_comb begin
    bus.stall            = 1'b0;
    bus.load_data        = '0;
    bus.access_fault     = 1'b0;
    bus.mem_address      = addr_lo;
    bus.mem_write_data   = bus.mem_read_data;
    bus.mem_write_enable = 1'b0;
`ifdef LSU_MISALIGNED_EN
    if (!rst && state == SECOND) begin
      bus.mem_address = addr_hi;
      if (bus.req_valid) begin
        if (bus.req_write) begin
          bus.mem_write_data   = merge_hi;
          bus.mem_write_enable = 1'b1;
        end else begin
          bus.load_data = extend(capture | (bus.mem_read_data << sh_hi), f3);
        end
      end
    end else
`endif
    if (!rst && bus.req_valid) begin
      if (!legal || split_fault) begin
        bus.access_fault = 1'b1;
      end
`ifdef LSU_MISALIGNED_EN
      else if (split) begin
        bus.stall = 1'b1;
        if (bus.req_write) begin
          bus.mem_write_data   = merge_lo;
          bus.mem_write_enable = 1'b1;
        end
      end
`endif
      else if (bus.req_write) begin
        bus.mem_write_data   = merge_lo;
        bus.mem_write_enable = 1'b1;
      end else begin
        bus.load_data = extend(bus.mem_read_data >> sh_lo, f3);
      end
    end
  end

endmodule
